md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit for the EX stage of the pipelined CPU, sitting beside the ALU and fed the same forwarded rs/rt operands. It executes mult/multu/div/divu with fixed multi-cycle latency, and holds the architectural HI/LO registers. It also services mthi/mtlo writes and presents HI/LO for mfhi/mflo. A registered `busy` output lets the hazard unit stall dependent MD instructions in ID.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (legal range 1..15).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (legal range 1..15).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `A`  in  32  rs operand, already forwarded.
- `B`  in  32  rt operand, already forwarded.
- `MDOp`  in  3  operation select: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- `start`  in  1  qualifies `MDOp` for the current EX instruction.
- `abort`  in  1  present only with `MDU_ABORT_EN`.
- `busy`  out  1  an operation is in flight.
- `HI`  out  32  architectural HI register.
- `LO`  out  32  architectural LO register.

## Operation
- Reset (`reset_n` low, asynchronous): HI=0, LO=0, count=0, busy=0, pending registers=0.
- Accept rule: an edge with `start`=1 and `busy`=0 accepts `MDOp`.
- When `start`=1 while `busy`=1, the request is ignored and all state is unchanged. The hazard unit guarantees this does not occur; the bench checks that it is harmless.
- mult: {pendHI,pendLO} <= $signed(A)*$signed(B), as a 64-bit result. count <= `MULT_CYCLES`.
- multu: same as mult, but unsigned.
- div, signed: pendLO = quotient, truncated toward zero. pendHI = remainder, which takes the sign of the dividend. count <= `DIV_CYCLES`.
  - Special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder, with the same latency as div.
- Divide by zero (div or divu with B=0): the unit still goes busy for `DIV_CYCLES` cycles, but HI/LO are left unchanged at completion.
- mthi: HI <= A at the accepting edge. No busy cycles.
- mtlo: LO <= A at the accepting edge. No busy cycles.
- Countdown: while count≠0, count decrements each edge. On the edge where count goes 1→0, HI/LO <= pendHI/pendLO, unless the operation was a divide by zero.
- `busy` = (count≠0). It is driven from a register, with no combinational path from inputs.
- HI/LO are plain registers. mfhi/mflo read them directly, and the hazard unit must stall mfhi/mflo while `busy` or `start` is high.

## Timing
- An op accepted at edge k raises `busy` from k+ and holds it for exactly N cycles. N is `MULT_CYCLES` or `DIV_CYCLES`.
- New HI/LO become visible after edge k+N, in the same cycle that `busy` falls.
- A back-to-back `start` in the cycle where `busy` has just fallen is accepted normally.
- mthi/mtlo: the new value is visible in the cycle after the accepting edge.
- Reset mid-operation: the operation is discarded immediately, with no partial HI/LO update.

## Configuration
- `MDU_ABORT_EN` defined:
  - adds the `abort` input, used for exception/interrupt flush;
  - `abort`=1 at an edge clears count to 0 and discards the pending result, leaving HI/LO unchanged;
  - `abort` with `start` in the same cycle suppresses the accept, including mthi/mtlo.
- `MDU_ABORT_EN` undefined: the port is absent, and operations always complete.

## Structure
Shared package holds:
- the `MDOp` encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
- the default latency constants.

One sub-module, `md_div_core`, is combinational. It has inputs dividend, divisor and a signed flag. It produces quotient, remainder and a div_by_zero flag, and it owns the sign and overflow rules. Multiply is written inline.

## Test plan
- Reset, then mult A=0xFFFFFFFE (-2), B=3:
  - `busy` is high for 5 cycles;
  - then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div A=-7 (0xFFFFFFF9), B=2:
  - `busy` is high for 10 cycles;
  - then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Signed overflow div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero:
  - setup: mthi A=0x1234, then mtlo A=0x5678 on the next cycle, giving HI=0x1234, LO=0x5678;
  - then divu with B=0 → `busy` is high for 10 cycles and HI/LO are unchanged.
- Interruptions:
  - `start`+mult while busy → ignored, and the original result lands on schedule;
  - `reset_n` low mid-div → HI=LO=0, busy=0 immediately;
  - with `MDU_ABORT_EN`, `abort` at cycle 3 of a mult → busy=0 next cycle, HI/LO unchanged.

Source files
------------

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the multiply/divide unit.
//   md_op_e       - encodings of the MDOp operation-select field
//   MD_*_CYCLES_* - default busy latencies for multiply and divide
// Optional feature macro used by md_unit: MDU_ABORT_EN (adds the abort input).
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7   // decoded as no operation
  } md_op_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_unit_div_core.sv
// md_div_core: combinational 32-bit divider.
//   i_dividend    in  32  dividend (rs)
//   i_divisor     in  32  divisor (rt)
//   i_is_signed   in  1   1 = two's-complement divide, 0 = unsigned
//   o_quotient    out 32  quotient, truncated toward zero
//   o_remainder   out 32  remainder, sign follows the dividend
//   o_div_by_zero out 1   divisor is zero; quotient/remainder forced to 0
module md_div_core
  import md_unit_pkg::*;
(
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  input  logic        i_is_signed,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder,
  output logic        o_div_by_zero
);

  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_safe_b;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;

  assign w_neg_a = i_is_signed & i_dividend[31];
  assign w_neg_b = i_is_signed & i_divisor[31];

  // Magnitudes as unsigned values. Negating 0x80000000 yields 0x80000000,
  // which is the correct unsigned magnitude 2^31, so the overflow case
  // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
  assign w_mag_a = w_neg_a ? (32'd0 - i_dividend) : i_dividend;
  assign w_mag_b = w_neg_b ? (32'd0 - i_divisor)  : i_divisor;

  assign o_div_by_zero = (i_divisor == 32'd0);

  // Substitute 1 for a zero divisor so the divider never sees /0.
  assign w_safe_b = o_div_by_zero ? 32'd1 : w_mag_b;
  assign w_q_mag  = o_div_by_zero ? 32'd0 : (w_mag_a / w_safe_b);
  assign w_r_mag  = o_div_by_zero ? 32'd0 : (w_mag_a % w_safe_b);

  // Quotient is negative when operand signs differ; remainder takes the
  // dividend's sign.
  assign o_quotient  = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_mag) : w_q_mag;
  assign o_remainder = w_neg_a ? (32'd0 - w_r_mag) : w_r_mag;

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding architectural HI/LO.
//   clk      in  1   clock, rising edge
//   reset_n  in  1   asynchronous active-low reset
//   A        in  32  rs operand (forwarded)
//   B        in  32  rt operand (forwarded)
//   MDOp     in  3   operation select (md_op_e)
//   start    in  1   qualifies MDOp; accepted only while not busy
//   abort    in  1   flush in-flight op (only when MDU_ABORT_EN is defined)
//   busy     out 1   operation in flight (count != 0, register-derived)
//   HI       out 32  architectural HI
//   LO       out 32  architectural LO
// Macro MDU_ABORT_EN: adds the abort input. Without it operations always
// complete once accepted.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,  // 1..15
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF    // 1..15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        start,
`ifdef MDU_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  logic [3:0]  r_count;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_dbz;      // in-flight op is a divide by zero: skip writeback
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  md_op_e      w_op;
  logic        w_mul_signed;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_div_by_zero;

  assign w_op = md_op_e'(MDOp);

  // One 64-bit multiplier serves both flavours: sign- or zero-extend the
  // operands to 64 bits; the low 64 bits of the product are then exact.
  assign w_mul_signed = (w_op == MD_MULT);
  assign w_a_ext = {{32{w_mul_signed & A[31]}}, A};
  assign w_b_ext = {{32{w_mul_signed & B[31]}}, B};
  assign w_prod  = w_a_ext * w_b_ext;

  md_div_core u_div_core (
    .i_dividend    (A),
    .i_divisor     (B),
    .i_is_signed   (w_op == MD_DIV),
    .o_quotient    (w_quot),
    .o_remainder   (w_rem),
    .o_div_by_zero (w_div_by_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= 4'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_dbz     <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
`ifdef MDU_ABORT_EN
      // Flush wins over both countdown and a same-cycle accept.
      if (abort) begin
        r_count   <= 4'd0;
        r_pend_hi <= 32'd0;
        r_pend_lo <= 32'd0;
        r_dbz     <= 1'b0;
      end else
`endif
      if (r_count != 4'd0) begin
        // Requests arriving while busy are dropped here.
        r_count <= r_count - 4'd1;
        if (r_count == 4'd1 && !r_dbz) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end else if (start) begin
        case (w_op)
          MD_MULT, MD_MULTU: begin
            r_pend_hi <= w_prod[63:32];
            r_pend_lo <= w_prod[31:0];
            r_dbz     <= 1'b0;
            r_count   <= 4'(MULT_CYCLES);
          end
          MD_DIV, MD_DIVU: begin
            r_pend_hi <= w_rem;
            r_pend_lo <= w_quot;
            r_dbz     <= w_div_by_zero;
            r_count   <= 4'(DIV_CYCLES);
          end
          MD_MTHI: r_hi <= A;
          MD_MTLO: r_lo <= A;
          default: ;
        endcase
      end
    end
  end

  assign busy = (r_count != 4'd0);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit (default latencies).
// Define MDU_ABORT_EN to also exercise the abort input.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDOp;
  logic        start;
`ifdef MDU_ABORT_EN
  logic        abort;
`endif
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;
  int n;

  md_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .A       (A),
    .B       (B),
    .MDOp    (MDOp),
    .start   (start),
`ifdef MDU_ABORT_EN
    .abort   (abort),
`endif
    .busy    (busy),
    .HI      (HI),
    .LO      (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, obs);
    end
  endtask

  // Present a request for one clock; returns at the falling edge after it.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDOp  = op;
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    MDOp  = 3'd0;
  endtask

  // Count falling edges with busy high; bounded so a stuck busy cannot hang.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    A = 32'd0; B = 32'd0; MDOp = 3'd0; start = 1'b0;
`ifdef MDU_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // mult -2 * 3 = -6
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("mult_busy", 32'(n), 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    // multu (2^32-1)^2 = 0xFFFFFFFE_00000001
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    check("multu_busy", 32'(n), 32'd5);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);

    // div -7 / 2 = -3 rem -1
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_busy", 32'(n), 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    // signed overflow
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("ovf_lo", LO, 32'h8000_0000);
    check("ovf_hi", HI, 32'h0000_0000);

    // mthi / mtlo visible the cycle after accept, no busy
    issue(MD_MTHI, 32'h0000_1234, 32'd0);
    check("mthi_hi", HI, 32'h0000_1234);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(MD_MTLO, 32'h0000_5678, 32'd0);
    check("mtlo_lo", LO, 32'h0000_5678);

    // divu by zero: busy full latency, HI/LO untouched
    issue(MD_DIVU, 32'd77, 32'd0);
    wait_idle(n);
    check("dbz_busy", 32'(n), 32'd10);
    check("dbz_hi", HI, 32'h0000_1234);
    check("dbz_lo", LO, 32'h0000_5678);

    // reserved op acts as none
    issue(3'd7, 32'h9999, 32'd1);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_hi", HI, 32'h0000_1234);

    // requests while busy are ignored; original mult 2*3 lands on schedule
    issue(MD_MULT, 32'd2, 32'd3);          // busy cycle 1 observed
    @(negedge clk);                        // busy cycle 2
    issue(MD_MTHI, 32'h0000_DEAD, 32'd0);  // busy cycle 3, ignored
    check("ign_mthi_hi", HI, 32'h0000_1234);
    issue(MD_MULT, 32'd7, 32'd7);          // busy cycle 4, ignored
    wait_idle(n);
    check("ign_tail_busy", 32'(n), 32'd2); // 3 of the 5 cycles already passed
    check("ign_hi", HI, 32'd0);
    check("ign_lo", LO, 32'd6);

    // back-to-back accept in the cycle busy falls: divu 100/7 = 14 rem 2
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_idle(n);
    check("b2b_busy", 32'(n), 32'd10);
    check("b2b_lo", LO, 32'd14);
    check("b2b_hi", HI, 32'd2);

    // reset mid-divide: immediate clear, no late writeback
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_hi", HI, 32'd0);
    check("rstmid_lo", LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("rstmid_late_lo", LO, 32'd0);
    check("rstmid_late_busy", {31'd0, busy}, 32'd0);

`ifdef MDU_ABORT_EN
    issue(MD_MTHI, 32'h0000_AAAA, 32'd0);
    issue(MD_MTLO, 32'h0000_BBBB, 32'd0);
    issue(MD_MULT, 32'd3, 32'd4);          // busy cycle 1
    @(negedge clk);                        // cycle 2
    abort = 1'b1;                          // asserted during cycle 3
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", HI, 32'h0000_AAAA);
    check("abort_lo", LO, 32'h0000_BBBB);
    abort = 1'b1;                          // abort suppresses a same-cycle mthi
    issue(MD_MTHI, 32'h0000_1111, 32'd0);
    abort = 1'b0;
    check("abort_mthi_hi", HI, 32'h0000_AAAA);
    repeat (6) @(negedge clk);
    check("abort_late_lo", LO, 32'h0000_BBBB);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
